// File: rtl/fm_read_ctrl_pkg.sv
// Shared network parameters, FSM state encoding and the beat-flag struct
// used by the feature-map read controller and its delay line.
package fm_read_ctrl_pkg;

  localparam int FM_DEPTH_DEF     = 64;
  localparam int NUM_KERNELS_DEF  = 2;
  localparam int READ_LATENCY_DEF = 2;

  // A width of at least one bit keeps degenerate depths (1) legal.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int FM_ADDR_W_DEF = clog2_min1(FM_DEPTH_DEF);
  localparam int FM_SEL_W_DEF  = clog2_min1(NUM_KERNELS_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } beat_t;

endpackage

// File: rtl/fm_read_ctrl_if.sv
// Read-control bus: start/clear requests in, address/select and
// beat qualifiers out toward the fm/weight buffers and the MAC array.
interface fm_read_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int SEL_W  = 1
);
  // start is a level request; it is only honoured while the controller
  // is idle. data_valid/first/last describe the mux output this cycle;
  // product_rdy is a single-cycle pulse with no handshake back.
  logic              start;
  logic              clear;
  logic [ADDR_W-1:0] addr;
  logic [SEL_W-1:0]  ram_select;
  logic              data_valid;
  logic              first;
  logic              last;
  logic              busy;
  logic              product_rdy;

  modport master (
    input  start, clear,
    output addr, ram_select, data_valid, first, last, busy, product_rdy
  );

  modport slave (
    output start, clear,
    input  addr, ram_select, data_valid, first, last, busy, product_rdy
  );
endinterface

// File: rtl/fm_read_ctrl_valid_delay_sr.sv
// Shift register that aligns the issue-time {valid, first, last} flags
// with the data appearing at the RAM read-port mux output.
module valid_delay_sr
  import fm_read_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  clear_i,
  input  beat_t beat_i,
  output beat_t beat_o
);

  beat_t sr_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= beat_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign beat_o = sr_q[DEPTH-1];

endmodule

// File: rtl/fm_read_ctrl.sv
// Feature-map read controller: sweeps every (addr, kernel) pair once per
// pass, then waits out the RAM/mux latency before flagging final sums.
module fm_read_ctrl
  import fm_read_ctrl_pkg::*;
#(
  parameter int FM_DEPTH     = FM_DEPTH_DEF,
  parameter int NUM_KERNELS  = NUM_KERNELS_DEF,
  parameter int READ_LATENCY = READ_LATENCY_DEF
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  fm_read_ctrl_if.master rd_if,
  output state_e         state_o
);

  localparam int ADDR_W  = clog2_min1(FM_DEPTH);
  localparam int SEL_W   = clog2_min1(NUM_KERNELS);
  localparam int DRAIN_W = clog2_min1(READ_LATENCY);

  localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(FM_DEPTH - 1);
  localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(NUM_KERNELS - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(READ_LATENCY - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               prdy_q, prdy_d;

  beat_t issue_beat;
  beat_t out_beat;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      sel_q   <= '0;
      drain_q <= '0;
      prdy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      drain_q <= drain_d;
      prdy_q  <= prdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    drain_d = drain_q;
    prdy_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        sel_d  = '0;
        if (rd_if.start) state_d = ST_READ;
      end
      ST_READ: begin
        // Kernel select is the fast counter; address advances on its wrap.
        if (sel_q == SEL_LAST) begin
          sel_d = '0;
          if (addr_q == ADDR_LAST) begin
            addr_d  = '0;
            drain_d = '0;
            state_d = ST_DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end else begin
          sel_d = sel_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          drain_d = '0;
          prdy_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (rd_if.clear) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      sel_d   = '0;
      drain_d = '0;
      prdy_d  = 1'b0;
    end
  end

  always_comb begin
    issue_beat       = '0;
    issue_beat.valid = (state_q == ST_READ);
    issue_beat.first = issue_beat.valid && (addr_q == '0) && (sel_q == '0);
    issue_beat.last  = issue_beat.valid && (addr_q == ADDR_LAST) && (sel_q == SEL_LAST);
  end

  valid_delay_sr #(
    .DEPTH (READ_LATENCY)
  ) u_delay (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (rd_if.clear),
    .beat_i  (issue_beat),
    .beat_o  (out_beat)
  );

  assign rd_if.addr        = addr_q;
  assign rd_if.ram_select  = sel_q;
  assign rd_if.data_valid  = out_beat.valid;
  assign rd_if.first       = out_beat.first;
  assign rd_if.last        = out_beat.last;
  assign rd_if.busy        = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign rd_if.product_rdy = prdy_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_fm_read_ctrl.sv
// Directed bench for fm_read_ctrl: a 4x2 latency-2 instance and a
// degenerate 1x1 latency-1 instance sharing one clock and reset.
module tb_fm_read_ctrl;
  import fm_read_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  state_e state_a;
  state_e state_b;

  fm_read_ctrl_if #(.ADDR_W(2), .SEL_W(1)) if_a ();
  fm_read_ctrl_if #(.ADDR_W(1), .SEL_W(1)) if_b ();

  fm_read_ctrl #(
    .FM_DEPTH(4), .NUM_KERNELS(2), .READ_LATENCY(2)
  ) dut_a (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .rd_if   (if_a),
    .state_o (state_a)
  );

  fm_read_ctrl #(
    .FM_DEPTH(1), .NUM_KERNELS(1), .READ_LATENCY(1)
  ) dut_b (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .rd_if   (if_b),
    .state_o (state_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] obs_a;
  logic [6:0] obs_b;
  assign obs_a = {if_a.addr, if_a.ram_select, if_a.data_valid, if_a.first,
                  if_a.last, if_a.busy, if_a.product_rdy};
  assign obs_b = {if_b.addr, if_b.ram_select, if_b.data_valid, if_b.first,
                  if_b.last, if_b.busy, if_b.product_rdy};

  // Expected {addr, sel, valid, first, last, busy, product_rdy} for the
  // nominal 4x2 pass, cycle 1 being the first READ cycle after edge 0.
  function automatic logic [7:0] exp_nom(input int c);
    logic [1:0] a;
    logic       s, v, f, l, b, p;
    a = (c >= 1 && c <= 8) ? 2'((c - 1) / 2) : 2'd0;
    s = (c >= 1 && c <= 8) ? 1'((c - 1) % 2) : 1'b0;
    v = (c >= 3 && c <= 10);
    f = (c == 3);
    l = (c == 10);
    b = (c >= 1 && c <= 10);
    p = (c == 11);
    return {a, s, v, f, l, b, p};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    if_a.start = 1'b0; if_a.clear = 1'b0;
    if_b.start = 1'b0; if_b.clear = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (obs_a !== 8'd0 || state_a !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_a got=%b/%0d exp=00000000/0", obs_a, state_a);
    end
    n_cmp++;
    if (obs_b !== 7'd0 || state_b !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_b got=%b/%0d exp=0000000/0", obs_b, state_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if (obs_a !== 8'd0 || state_a !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_release got=%b/%0d exp=00000000/0", obs_a, state_a);
    end
  endtask

  task automatic test_nominal();
    logic [7:0] exp;
    @(negedge clk);
    if_a.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 14; c++) begin
      #2;
      if (c == 1) if_a.start = 1'b0;
      exp = exp_nom(c);
      n_cmp++;
      if (obs_a !== exp) begin
        n_fail++;
        $display("FAIL nominal c=%0d got=%b exp=%b", c, obs_a, exp);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    @(negedge clk);
    if_a.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 28; c++) begin
      #2;
      if (c == 20) if_a.start = 1'b0;
      exp = (c <= 12) ? exp_nom(c) : exp_nom(c - 12);
      n_cmp++;
      if (obs_a !== exp) begin
        n_fail++;
        $display("FAIL back_to_back c=%0d got=%b exp=%b", c, obs_a, exp);
      end
      if (c == 12) begin
        n_cmp++;
        if (state_a !== ST_IDLE) begin
          n_fail++;
          $display("FAIL b2b_idle_gap got=%0d exp=%0d", state_a, ST_IDLE);
        end
      end
      @(posedge clk);
    end
  endtask

  task automatic test_clear();
    logic [7:0] exp;
    @(negedge clk);
    if_a.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 14; c++) begin
      #2;
      if (c == 1) if_a.start = 1'b0;
      exp = (c <= 5) ? exp_nom(c) : 8'd0;
      n_cmp++;
      if (obs_a !== exp) begin
        n_fail++;
        $display("FAIL clear c=%0d got=%b exp=%b", c, obs_a, exp);
      end
      if (c == 5) if_a.clear = 1'b1;
      if (c == 6) if_a.clear = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic test_start_while_busy();
    logic [7:0] exp;
    int beats;
    int pulses;
    beats  = 0;
    pulses = 0;
    @(negedge clk);
    if_a.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 16; c++) begin
      #2;
      if (c == 1) if_a.start = 1'b0;
      exp = exp_nom(c);
      n_cmp++;
      if (obs_a !== exp) begin
        n_fail++;
        $display("FAIL start_busy c=%0d got=%b exp=%b", c, obs_a, exp);
      end
      if (if_a.data_valid === 1'b1) beats++;
      if (if_a.product_rdy === 1'b1) pulses++;
      if (c == 4) if_a.start = 1'b1;
      if (c == 5) if_a.start = 1'b0;
      @(posedge clk);
    end
    n_cmp++;
    if (beats != 8) begin
      n_fail++;
      $display("FAIL start_busy_beats got=%0d exp=8", beats);
    end
    n_cmp++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL start_busy_pulses got=%0d exp=1", pulses);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] exp;
    @(negedge clk);
    if_a.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 9; c++) begin
      #2;
      if (c == 1) if_a.start = 1'b0;
      exp = exp_nom(c);
      n_cmp++;
      if (obs_a !== exp) begin
        n_fail++;
        $display("FAIL async_pre c=%0d got=%b exp=%b", c, obs_a, exp);
      end
      if (c < 9) @(posedge clk);
    end
    n_cmp++;
    if (state_a !== ST_DRAIN) begin
      n_fail++;
      $display("FAIL async_in_drain got=%0d exp=%0d", state_a, ST_DRAIN);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs_a !== 8'd0 || state_a !== ST_IDLE) begin
      n_fail++;
      $display("FAIL async_immediate got=%b/%0d exp=00000000/0", obs_a, state_a);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #2;
      n_cmp++;
      if (obs_a !== 8'd0 || state_a !== ST_IDLE) begin
        n_fail++;
        $display("FAIL async_after c=%0d got=%b/%0d exp=00000000/0", c, obs_a, state_a);
      end
    end
  endtask

  task automatic test_degenerate();
    logic [6:0] exp_tab [5];
    exp_tab[0] = 7'b0000010;
    exp_tab[1] = 7'b0011110;
    exp_tab[2] = 7'b0000001;
    exp_tab[3] = 7'b0000000;
    exp_tab[4] = 7'b0000000;
    @(negedge clk);
    if_b.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      #2;
      if (c == 1) if_b.start = 1'b0;
      n_cmp++;
      if (obs_b !== exp_tab[c-1]) begin
        n_fail++;
        $display("FAIL degenerate c=%0d got=%b exp=%b", c, obs_b, exp_tab[c-1]);
      end
      @(posedge clk);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_nominal();
    test_back_to_back();
    test_clear();
    test_start_while_busy();
    test_async_reset();
    test_degenerate();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
